// File: rtl/rsa_keygen_seq.sv
// Key-generation sequencer: drives the n/phi and e/d engines, shares the LFSR enable, retries on
// watchdog expiry and holds the final key set. Define KEYGEN_STATS_EN to add the gen_cycles counter.
//
// state  | meaning
// S_IDLE | waiting for start; LFSR free-runs when en=1
// S_NPHI | n/phi engine running, waiting for nphi_valid
// S_ED   | e/d engine running on phi_out, waiting for ed_valid
module rsa_keygen_seq #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int MAX_RETRY      = 3,
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1),
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             abort,
  output logic             nphi_start,
  input  logic [WIDTH-1:0] nphi_n,
  input  logic [WIDTH-1:0] nphi_phi,
  input  logic             nphi_valid,
  input  logic             nphi_rng_req,
  output logic             ed_clr,
  output logic             ed_en,
  output logic [WIDTH-1:0] phi_out,
  input  logic [WIDTH-1:0] ed_e,
  input  logic [WIDTH-1:0] ed_d,
  input  logic             ed_valid,
  input  logic             ed_rng_req,
  output logic             rng_en,
  output logic [WIDTH-1:0] n_key,
  output logic [WIDTH-1:0] e_key,
  output logic [WIDTH-1:0] d_key,
  output logic             key_valid,
  output logic             done,
  output logic             busy,
  output logic             error,
`ifdef KEYGEN_STATS_EN
  output logic [31:0]      gen_cycles,
`endif
  output logic [RCW-1:0]   retry_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_NPHI, S_ED} state_t;

  localparam logic [TCW-1:0] TIMER_LAST = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [RCW-1:0] RETRY_MAX  = RCW'(MAX_RETRY);

  state_t         state, state_nxt;
  logic [TCW-1:0] timer;
  logic           expired, can_retry;
  logic           accept, nphi_ok, ed_ok, retry, fail, aborted;

  assign expired   = (timer == TIMER_LAST);
  assign can_retry = (retry_cnt < RETRY_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Priority inside a running state: abort, then valid, then watchdog expiry.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    nphi_ok   = 1'b0;
    ed_ok     = 1'b0;
    retry     = 1'b0;
    fail      = 1'b0;
    aborted   = 1'b0;
    rng_en    = 1'b0;
    ed_clr    = 1'b1;
    case (state)
      S_IDLE: begin
        rng_en = en;
        if (start && en) begin
          accept    = 1'b1;
          state_nxt = S_NPHI;
        end
      end
      S_NPHI: begin
        rng_en = nphi_rng_req;
        if (abort) begin
          aborted   = 1'b1;
          state_nxt = S_IDLE;
        end else if (nphi_valid) begin
          nphi_ok   = 1'b1;
          state_nxt = S_ED;
        end else if (expired) begin
          retry     = can_retry;
          fail      = !can_retry;
          state_nxt = can_retry ? S_NPHI : S_IDLE;
        end
      end
      S_ED: begin
        rng_en = ed_rng_req | nphi_rng_req;
        ed_clr = 1'b0;
        if (abort) begin
          aborted   = 1'b1;
          state_nxt = S_IDLE;
        end else if (ed_valid) begin
          ed_ok     = 1'b1;
          state_nxt = S_IDLE;
        end else if (expired) begin
          retry     = can_retry;
          fail      = !can_retry;
          state_nxt = can_retry ? S_NPHI : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer      <= '0;
      retry_cnt  <= '0;
      phi_out    <= '0;
      n_key      <= '0;
      e_key      <= '0;
      d_key      <= '0;
      key_valid  <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
      nphi_start <= 1'b0;
      ed_en      <= 1'b0;
    end else begin
      nphi_start <= accept | retry;
      ed_en      <= nphi_ok;
      done       <= ed_ok;
      if (state != S_IDLE) timer <= timer + 1'b1;
      if (accept) begin
        busy      <= 1'b1;
        key_valid <= 1'b0;
        error     <= 1'b0;
        retry_cnt <= '0;
        timer     <= '0;
      end
      if (nphi_ok) begin
        phi_out <= nphi_phi;
        n_key   <= nphi_n;
      end
      if (ed_ok) begin
        e_key     <= ed_e;
        d_key     <= ed_d;
        key_valid <= 1'b1;
        busy      <= 1'b0;
      end
      if (retry) begin
        retry_cnt <= retry_cnt + 1'b1;
        timer     <= '0;
      end
      if (fail) begin
        error <= 1'b1;
        busy  <= 1'b0;
      end
      if (aborted) busy <= 1'b0;
    end
  end

`ifdef KEYGEN_STATS_EN
  // Counts every non-idle cycle of the current generation, so retries are included.
  always_ff @(posedge clk) begin
    if (rst)                                      gen_cycles <= '0;
    else if (accept)                              gen_cycles <= '0;
    else if (state != S_IDLE && gen_cycles != '1) gen_cycles <= gen_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_rsa_keygen_seq.sv
// Scoreboard bench for rsa_keygen_seq: attempt-level engine scenarios predict each generation's
// outcome, a monitor checks it when busy falls, and per-cycle handshake outputs are checked in the driver.
module tb_rsa_keygen_seq;
  localparam int W     = 32;
  localparam int TO    = 64;
  localparam int MR    = 2;
  localparam int RCW   = 2;
  localparam int STALL = 99;
  localparam int K_DONE = 0, K_ERR = 1, K_ABORT = 2;

  logic clk = 1'b0;
  logic rst, en, start, abort;
  logic nphi_start, nphi_valid, nphi_rng_req;
  logic [W-1:0] nphi_n, nphi_phi;
  logic ed_clr, ed_en, ed_valid, ed_rng_req, rng_en;
  logic [W-1:0] phi_out, ed_e, ed_d, n_key, e_key, d_key;
  logic key_valid, done, busy, error;
  logic [RCW-1:0] retry_cnt;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  typedef struct {
    int kind;
    int stamp;
    int retry;
    logic [W-1:0] n, phi, e, d;
  } exp_t;
  exp_t q[$];

  logic [W-1:0] m_n = '0, m_phi = '0, m_e = '0, m_d = '0;
  int g_na[3], g_eb[3];
  logic [W-1:0] g_nv[3], g_pv[3], g_ev[3], g_dv[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  rsa_keygen_seq #(.WIDTH(W), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort),
    .nphi_start(nphi_start), .nphi_n(nphi_n), .nphi_phi(nphi_phi),
    .nphi_valid(nphi_valid), .nphi_rng_req(nphi_rng_req),
    .ed_clr(ed_clr), .ed_en(ed_en), .phi_out(phi_out),
    .ed_e(ed_e), .ed_d(ed_d), .ed_valid(ed_valid), .ed_rng_req(ed_rng_req),
    .rng_en(rng_en), .n_key(n_key), .e_key(e_key), .d_key(d_key),
    .key_valid(key_valid), .done(done), .busy(busy), .error(error),
    .retry_cnt(retry_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Monitor: a generation ends when busy falls; compare against the oldest prediction.
  logic busy_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst) busy_prev = 1'b0;
    else begin
      if (busy_prev && !busy) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_end: generation ended with nothing expected (cycle %0d)", cyc_cnt);
        end else begin
          exp_t x;
          x = q.pop_front();
          chk("end_cycle", cyc_cnt, x.stamp);
          chk("done", done, x.kind == K_DONE);
          chk("key_valid", key_valid, x.kind == K_DONE);
          chk("error", error, x.kind == K_ERR);
          chk("retry_cnt", retry_cnt, x.retry);
          chk("n_key", n_key, x.n);
          chk("phi_out", phi_out, x.phi);
          chk("e_key", e_key, x.e);
          chk("d_key", d_key, x.d);
        end
      end else if (done) chk("done_stray", done, 1'b0);
      busy_prev = busy;
    end
  end

  task automatic setup(input int a0, input int b0, input int a1, input int b1,
                       input int a2, input int b2);
    g_na[0] = a0; g_eb[0] = b0; g_na[1] = a1; g_eb[1] = b1; g_na[2] = a2; g_eb[2] = b2;
    for (int k = 0; k < 3; k++) begin
      g_nv[k] = $urandom; g_pv[k] = $urandom; g_ev[k] = $urandom; g_dv[k] = $urandom;
    end
  endtask

  // One generation. Cycle 0 is the cycle where the first nphi_start is high; attempt i
  // owns cycles TO*i .. TO*i+TO-1 and sees its engine events at offsets g_na/g_eb.
  task automatic gen(input int ab, input bit dbl);
    int end_c, kind, rt;
    exp_t x;
    logic [W-1:0] nn, pp, ee, dd;
    end_c = -1; kind = K_ERR; rt = MR;
    nn = m_n; pp = m_phi; ee = m_e; dd = m_d;
    for (int i = 0; i <= MR; i++) begin
      if (g_na[i] < TO && g_eb[i] > g_na[i] && g_eb[i] < TO) begin
        end_c = TO * i + g_eb[i]; kind = K_DONE; rt = i;
        break;
      end
      if (i == MR) end_c = TO * i + TO - 1;
    end
    if (ab >= 0 && ab <= end_c) begin
      end_c = ab; kind = K_ABORT; rt = ab / TO;
    end
    for (int i = 0; i <= MR; i++)
      if (g_na[i] < TO && TO * i + g_na[i] < end_c) begin nn = g_nv[i]; pp = g_pv[i]; end
    if (kind == K_DONE) begin ee = g_ev[rt]; dd = g_dv[rt]; end

    @(negedge clk); en = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    x.kind = kind; x.stamp = cyc_cnt + end_c + 1; x.retry = rt;
    x.n = nn; x.phi = pp; x.e = ee; x.d = dd;
    q.push_back(x);
    m_n = nn; m_phi = pp; m_e = ee; m_d = dd;

    for (int cyc = 0; cyc <= end_c + 3; cyc++) begin
      int i, c;
      bit act, in_ed, exp_rng;
      i = (cyc / TO > MR) ? MR : cyc / TO;
      c = cyc % TO;
      act = (cyc <= end_c);
      in_ed = act && g_na[i] < TO && c > g_na[i];
      nphi_valid   = act && (c == g_na[i] || (dbl && c == g_na[i] + 1));
      nphi_n       = (act && c == g_na[i]) ? g_nv[i] : W'($urandom);
      nphi_phi     = (act && c == g_na[i]) ? g_pv[i] : W'($urandom);
      ed_valid     = (act && c == g_eb[i]) || (dbl && cyc == end_c + 2);
      ed_e         = (act && c == g_eb[i]) ? g_ev[i] : W'($urandom);
      ed_d         = (act && c == g_eb[i]) ? g_dv[i] : W'($urandom);
      abort        = (cyc == ab);
      start        = act && ($urandom_range(0, 9) == 0);
      en           = 1'($urandom_range(0, 1));
      nphi_rng_req = 1'($urandom_range(0, 1));
      ed_rng_req   = 1'($urandom_range(0, 1));
      #1;
      exp_rng = !act ? en : (in_ed ? (ed_rng_req | nphi_rng_req) : nphi_rng_req);
      chk("nphi_start", nphi_start, act && c == 0);
      chk("ed_en", ed_en, act && g_na[i] < TO && c == g_na[i] + 1);
      chk("ed_clr", ed_clr, !in_ed);
      chk("rng_en", rng_en, exp_rng);
      @(negedge clk);
    end
    nphi_valid = 1'b0; ed_valid = 1'b0; abort = 1'b0; start = 1'b0; en = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; abort = 1'b0;
    nphi_valid = 1'b0; nphi_rng_req = 1'b0; ed_valid = 1'b0; ed_rng_req = 1'b0;
    nphi_n = '0; nphi_phi = '0; ed_e = '0; ed_d = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_keys", {n_key, e_key}, 64'd0);
    chk("rst_d_phi", {d_key, phi_out}, 64'd0);
    chk("rst_flags", {key_valid, done, error, nphi_start, ed_en}, 5'b0);
    chk("rst_ed_clr", ed_clr, 1'b1);
    chk("rst_retry", retry_cnt, 0);
    chk("idle_rng_en0", rng_en, 1'b0);
    en = 1'b1; #1;
    chk("idle_rng_en1", rng_en, 1'b1);
    @(negedge clk); rst = 1'b0;

    // start with en=0 is ignored
    @(negedge clk); en = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; en = 1'b1;
    chk("start_no_en_busy", busy, 1'b0);
    chk("start_no_en_nphi", nphi_start, 1'b0);

    // reference key set
    setup(10, 30, STALL, STALL, STALL, STALL);
    g_nv[0] = 32'h0D5C0C6B; g_pv[0] = 32'h0D5AF2E8; g_ev[0] = 32'h00010001; g_dv[0] = 32'h0B6A5D41;
    gen(-1, 1'b0);
    // e/d never answers: three attempts then error
    setup(10, STALL, 10, STALL, 10, STALL);
    gen(-1, 1'b0);
    // n/phi stalls once, second attempt succeeds
    setup(STALL, STALL, 8, 20, STALL, STALL);
    gen(-1, 1'b0);
    // abort 5 cycles into ED, then a normal generation
    setup(10, STALL, STALL, STALL, STALL, STALL);
    gen(16, 1'b0);
    setup(12, 40, STALL, STALL, STALL, STALL);
    gen(-1, 1'b0);
    // ed_valid on the watchdog cycle, plus duplicate ticks
    setup(10, 63, STALL, STALL, STALL, STALL);
    gen(-1, 1'b1);

    // abort while idle has no effect
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("idle_abort_busy", busy, 1'b0);
    chk("idle_abort_kv", key_valid, 1'b1);

    for (int r = 0; r < 20; r++) begin
      int a[3], b[3];
      for (int k = 0; k < 3; k++) begin
        a[k] = ($urandom_range(0, 3) == 0) ? STALL : int'($urandom_range(0, 50));
        b[k] = (a[k] == STALL || $urandom_range(0, 3) == 0) ? STALL
               : int'($urandom_range(a[k] + 1, TO - 1));
      end
      setup(a[0], b[0], a[1], b[1], a[2], b[2]);
      gen(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 150)) : -1,
          1'($urandom_range(0, 1)));
    end

    // reset in the middle of a generation
    @(negedge clk); en = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_n_key", n_key, '0);
    chk("midrst_kv", key_valid, 1'b0);
    chk("midrst_ed_clr", ed_clr, 1'b1);
    chk("midrst_retry", retry_cnt, 0);
    m_n = '0; m_phi = '0; m_e = '0; m_d = '0;
    @(negedge clk); rst = 1'b0;
    setup(5, 25, STALL, STALL, STALL, STALL);
    gen(-1, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rsa_keygen_seq.md
Name: rsa_keygen_seq

Overview:
- Parametrised successor to the fixed 32-bit key-generation top level.
- Sequences an external n/phi engine and an external e/d engine, and arbitrates the shared LFSR enable between them.
- Holds n, e and d in output registers until the next generation, instead of exposing 1-cycle valid ticks.
- Adds an abort input, a per-attempt watchdog with automatic retry using fresh randomness, and a sticky error flag.

Parameters:
WIDTH, 32, key/phi width in bits
TIMEOUT_CYCLES, 1048576, max cycles per attempt (NPHI+ED combined) before retry; must be >=2
MAX_RETRY, 3, number of retries after the first attempt before declaring error; 0 allowed
TCW, $clog2(TIMEOUT_CYCLES+1), derived timer width (localparam)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  key-generation mode selected; LFSR free-runs while idle and en=1
start  in  1  request new key set; accepted only in IDLE with en=1
abort  in  1  cancel generation; return to IDLE
nphi_start  out  1  1-cycle pulse to n/phi engine
nphi_n  in  WIDTH  modulus from n/phi engine
nphi_phi  in  WIDTH  totient from n/phi engine
nphi_valid  in  1  n/phi valid tick
nphi_rng_req  in  1  n/phi engine needs LFSR advance
ed_clr  out  1  synchronous clear to e/d engine
ed_en  out  1  1-cycle pulse: phi_out valid, start e/d search
phi_out  out  WIDTH  registered phi to e/d engine
ed_e  in  WIDTH  public exponent
ed_d  in  WIDTH  private exponent
ed_valid  in  1  e/d valid tick
ed_rng_req  in  1  e/d engine needs LFSR advance
rng_en  out  1  LFSR enable
n_key, e_key, d_key  out  WIDTH each  held keys
key_valid  out  1  held keys form a complete set
done  out  1  1-cycle pulse on successful completion
busy  out  1  generation in progress
error  out  1  retries exhausted; sticky until next accepted start
retry_cnt  out  $clog2(MAX_RETRY+1) (min 1)  retries used in current/last generation

Behaviour:
- Reset: state IDLE; all key regs, phi_out, timer, retry_cnt = 0; key_valid, done, busy, error, nphi_start, ed_en = 0; ed_clr = 1.
- Outputs nphi_start, ed_en, done, busy, error, key regs are registered.
- rng_en (combinational): IDLE -> en; NPHI -> nphi_rng_req; ED -> ed_rng_req | nphi_rng_req.
- ed_clr = 1 in every state except ED.
- IDLE:
  - start&en -> NPHI next cycle; nphi_start=1 that cycle.
  - busy<=1; key_valid<=0; error<=0; retry_cnt<=0; timer<=0.
  - start with en=0 ignored; start while busy ignored.
- NPHI:
  - Timer increments each cycle.
  - nphi_valid -> phi_out<=nphi_phi, n_key<=nphi_n, ed_en pulse next cycle, -> ED.
  - Extra nphi_valid ticks in ED ignored.
- ED:
  - Timer continues.
  - First ed_valid -> e_key<=ed_e, d_key<=ed_d, key_valid<=1, done pulse, busy<=0 -> IDLE.
- Watchdog:
  - In NPHI/ED, timer==TIMEOUT_CYCLES-1 with no valid that cycle -> timeout.
  - If retry_cnt<MAX_RETRY: retry_cnt++, timer<=0, nphi_start pulse, -> NPHI; ed_clr asserted at least 1 cycle.
  - Else: error<=1, busy<=0 -> IDLE; n_key left at last value; key_valid stays 0.
- Simultaneous valid and timeout: valid wins.
- abort (any non-IDLE state): -> IDLE next cycle.
  - busy<=0, no done, key_valid stays 0, error unchanged.
  - abort outranks valid and timeout in the same cycle. abort in IDLE: no effect.
- rst mid-operation: same as reset; overrides everything.

Optional Feature:
KEYGEN_STATS_EN:
- Defined: adds output gen_cycles [31:0], the saturating count of cycles from accepted start to done/error/abort (inclusive of retries). Cleared on accepted start; held afterwards.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- WIDTH=32, TIMEOUT_CYCLES=64: start; model returns nphi_valid at cycle 10 (n=0x0D5C0C6B, phi=0x0D5AF2E8), ed_valid at cycle 30 (e=0x10001, d=0x0B6A5D41) -> ed_en 1 cycle after nphi_valid, phi_out=0x0D5AF2E8, done 1 pulse, keys held, key_valid=1, busy=0, retry_cnt=0.
- Model never raises ed_valid, MAX_RETRY=2 -> nphi_start at cycles 0, 64, 128; error=1 and busy=0 at cycle 192; retry_cnt=2; key_valid=0.
- Stall n/phi once (timeout), succeed on the 2nd attempt -> done, retry_cnt=1, error=0.
- abort 5 cycles into ED -> IDLE next cycle, ed_clr=1, no done, key_valid=0; a subsequent start succeeds normally.
- ed_valid and timeout in the same cycle -> success, no retry. ed_valid twice -> only the first is latched.
- rng_en: idle with en=1 -> 1; idle with en=0 -> 0; NPHI with nphi_rng_req toggling -> rng_en tracks it exactly.
